fetch_pc_unit: RTL
==================

Name: fetch_pc_unit

Overview:
- Instruction-fetch stage: owns the PC, issues instruction-memory requests and fills the IF/ID pipeline register.
- Consumes the branch/jump decision (`taken`) and target resolved in ID by the quick-compare stage.
- Honours the MIPS branch delay slot, hazard-unit stalls and a variable-latency instruction memory.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- DELAY_SLOT, 1, 1 = the instruction after a taken branch/jump executes; 0 = it is squashed (IF/ID valid cleared).

Ports:
- clk  in  1  pipeline clock, all state on the rising edge
- reset  in  1  synchronous, active-high; clears all state on the next rising edge
- stall  in  1  hazard unit: hold IF/ID and PC this cycle
- taken  in  1  branch/jump decision from ID compare; meaningful only when if_id_valid=1 and stall=0
- branch_target  in  32  redirect address, valid with taken
- imem_req  out  1  fetch request; held until imem_ready
- imem_addr  out  32  fetch address = current PC; stable while imem_req=1 and imem_ready=0
- imem_rdata  in  32  instruction word, valid when imem_ready=1
- imem_ready  in  1  memory returns imem_rdata this cycle (latency >= 0 cycles after request)
- if_id_instr  out  32  registered instruction to ID
- if_id_pc4  out  32  registered PC+4 of that instruction
- if_id_valid  out  1  IF/ID holds a real instruction (0 = bubble)

Behaviour:
- Reset values:
  - pc=RESET_PC, state=FETCH, imem_req=0 during the reset cycle then 1.
  - if_id_instr=0, if_id_pc4=0, if_id_valid=0.
  - hold buffer empty, redirect_pend=0.
- States:
  - FETCH: request outstanding.
  - HOLD: fetched word parked in the one-entry hold buffer because stall=1.
- FETCH, imem_ready=1, stall=0:
  - IF/ID <= {imem_rdata, pc+4, valid=1}.
  - pc <= next_pc; stay FETCH.
  - Zero-bubble throughput: one instruction per cycle when memory is ready every cycle.
- FETCH, imem_ready=1, stall=1:
  - Capture {imem_rdata, pc+4} into the hold buffer; IF/ID unchanged.
  - imem_req=0; go HOLD.
- FETCH, imem_ready=0:
  - If stall=0, IF/ID <= bubble (valid=0); otherwise IF/ID unchanged.
  - pc unchanged.
- HOLD, stall=0:
  - IF/ID <= buffer (valid=1); pc <= next_pc; go FETCH.
  - New request is issued on the following cycle.
- HOLD, stall=1: no change.
- Redirect accept:
  - Condition: taken=1 & stall=0 & if_id_valid=1.
  - Latch redirect_pc=branch_target, redirect_pend=1 (accepted exactly once per branch in ID).
- Delay slot: the instruction fetched at branch_pc+4 is the delay slot, i.e. the next instruction delivered to IF/ID after redirect accept.
- next_pc (evaluated when an instruction is delivered to IF/ID or buffer):
  - If redirect_pend=1 and the delivered instruction is the delay slot: next_pc = redirect_pc, clear redirect_pend.
  - Otherwise next_pc = pc+4 (32-bit wrap: 32'hFFFF_FFFC+4 = 0).
- Same-cycle case: if redirect accept coincides with delivery of the delay slot, use branch_target directly; pend is not set.
- DELAY_SLOT=0: the delay-slot instruction is written with valid=0 instead of 1; PC sequencing is identical.
- Reset mid-fetch: the outstanding request is abandoned; imem_ready on the reset cycle is ignored. The memory must tolerate a dropped request.
- Stall while redirect_pend=1: pend is retained until the delay slot is delivered.
- imem_addr[1:0] is always 2'b00. A misaligned branch_target is forced-aligned by zeroing bits [1:0].

Test Plan:
- Reset, imem_ready=1 constant, memory returns addr as data -> after reset, if_id_pc4 = 4, 8, 12 on consecutive cycles, if_id_valid=1, no bubbles.
- BEQ at 0x10 in ID, taken=1, branch_target=0x40, ready=1 -> IF/ID sequence pc4 0x14, 0x18 (delay slot, valid=1), then 0x44.
- Same branch, imem_ready held 0 for 3 cycles covering the accept cycle -> 3 bubbles (valid=0); delay slot 0x18 delivered; then fetch addr 0x40; redirect applied once.
- stall=1 for 2 cycles while word for pc=0x20 returns -> word held; imem_req=0 during HOLD; IF/ID unchanged; after stall drops IF/ID gets pc4=0x24, then addr 0x24 requested.
- DELAY_SLOT=0, taken branch at 0x10 -> 0x18 entry has if_id_valid=0, next valid entry pc4=0x44.
- Assert reset during HOLD with redirect_pend=1 -> next cycle pc=RESET_PC, if_id_valid=0, pend cleared; later fetches sequential from RESET_PC.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: owns the PC, issues instruction-memory requests and
// fills the IF/ID register, honouring delay slots, stalls and memory latency.
module fetch_pc_unit #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter logic        DELAY_SLOT = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        stall,
   input  logic        taken,
   input  logic [31:0] branch_target,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_ready,
   output logic [31:0] if_id_instr,
   output logic [31:0] if_id_pc4,
   output logic        if_id_valid
);

   typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] pc_plus4;
   logic [31:0] target_aligned;
   logic [31:0] redirect_pc_q, redirect_pc_d;
   logic        redirect_pend_q, redirect_pend_d;
   logic [31:0] buf_instr_q, buf_pc4_q;
   logic        accept;
   logic        deliver;
   logic        capture;
   logic        bubble;
   logic        is_slot;
   logic [31:0] id_instr_d, id_pc4_d;
   logic        id_valid_d;

   assign pc_plus4       = pc_q + 32'd4;
   assign target_aligned = branch_target & 32'hFFFF_FFFC;
   assign accept         = taken & ~stall & if_id_valid;
   assign imem_req       = (state_q == FETCH) & ~reset;
   assign imem_addr      = pc_q & 32'hFFFF_FFFC;

   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      redirect_pc_d   = redirect_pc_q;
      redirect_pend_d = redirect_pend_q;
      deliver         = 1'b0;
      capture         = 1'b0;
      bubble          = 1'b0;
      id_instr_d      = if_id_instr;
      id_pc4_d        = if_id_pc4;
      id_valid_d      = if_id_valid;

      unique case (state_q)
         FETCH: begin
            if (imem_ready) begin
               if (!stall) begin
                  deliver    = 1'b1;
                  id_instr_d = imem_rdata;
                  id_pc4_d   = pc_plus4;
               end else begin
                  capture = 1'b1;
                  state_d = HOLD;
               end
            end else if (!stall) begin
               bubble = 1'b1;
            end
         end
         HOLD: begin
            if (!stall) begin
               deliver    = 1'b1;
               id_instr_d = buf_instr_q;
               id_pc4_d   = buf_pc4_q;
               state_d    = FETCH;
            end
         end
         default: state_d = FETCH;
      endcase

      // A delivery coinciding with accept, or following a pending accept, is the delay slot.
      is_slot = accept | redirect_pend_q;

      if (deliver) begin
         if (accept)
            pc_d = target_aligned;
         else if (redirect_pend_q)
            pc_d = redirect_pc_q;
         else
            pc_d = pc_plus4;
         redirect_pend_d = 1'b0;
         id_valid_d      = DELAY_SLOT | ~is_slot;
      end else if (accept) begin
         redirect_pend_d = 1'b1;
         redirect_pc_d   = target_aligned;
      end

      if (bubble)
         id_valid_d = 1'b0;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q         <= FETCH;
         pc_q            <= RESET_PC & 32'hFFFF_FFFC;
         redirect_pc_q   <= '0;
         redirect_pend_q <= 1'b0;
         buf_instr_q     <= '0;
         buf_pc4_q       <= '0;
         if_id_instr     <= '0;
         if_id_pc4       <= '0;
         if_id_valid     <= 1'b0;
      end else begin
         state_q         <= state_d;
         pc_q            <= pc_d;
         redirect_pc_q   <= redirect_pc_d;
         redirect_pend_q <= redirect_pend_d;
         if (capture) begin
            buf_instr_q <= imem_rdata;
            buf_pc4_q   <= pc_plus4;
         end
         if_id_instr <= id_instr_d;
         if_id_pc4   <= id_pc4_d;
         if_id_valid <= id_valid_d;
      end
   end

endmodule
